// File: rtl/alu_cmp_pkg.sv
// Shared definitions for the ALU compare path: op encodings, FSM state codes
// and the op decode used to turn lt/eq/gt flags into a single truth bit.
package alu_cmp_pkg;

  // Compare op encodings as they arrive on the op input.
  localparam logic [1:0] CMP_LT = 2'b00;
  localparam logic [1:0] CMP_LE = 2'b01;
  localparam logic [1:0] CMP_EQ = 2'b10;
  localparam logic [1:0] CMP_GT = 2'b11;

  // Sequencer state codes. Plain constants keep the encoding visible in
  // waveforms and compatible with older tools that choke on enums in ports.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  // Decode a compare op against a set of relation flags.
  function automatic logic op_true(input logic [1:0] op,
                                   input logic        lt,
                                   input logic        eq,
                                   input logic        gt);
    logic t;
    case (op)
      CMP_LT:  t = lt;
      CMP_LE:  t = lt | eq;
      CMP_EQ:  t = eq;
      default: t = gt;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/slice_compare.sv
// Unsigned compare of one operand slice. Purely combinational; the sequencer
// feeds it the currently selected slice of A and B each cycle.
module slice_compare #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  output logic             lt,
  output logic             eq
);

  // Relation of x to y; gt is implied by !lt && !eq.
  always_comb begin
    lt = (x < y);
    eq = (x == y);
  end

endmodule

// File: rtl/seq_magnitude_compare.sv
// Multi-cycle magnitude comparator. Operands are walked MSB slice first,
// SLICE bits per cycle, stopping at the first slice that differs. Signed
// compares are turned into unsigned ones by flipping the operand sign bits
// at capture (offset-binary), so the slice path never needs to know the mode.
module seq_magnitude_compare
  import alu_cmp_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NSLICE - 1);

  // Reject geometries the slice walk cannot cover exactly.
  if (SLICE < 1 || WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_bad_geometry
    $error("seq_magnitude_compare: WIDTH must be >= 2 and a multiple of SLICE >= 1");
  end

  // Sequencer state and captured request.
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Result registers; these hold until the next accepted request finishes.
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             res_q, res_d;

  // Slice currently under examination.
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic             slice_lt;
  logic             slice_eq;

  // Offset-binary bias: flipping the sign bit maps two's-complement order
  // onto unsigned order, so the same slice compare serves both modes.
  function automatic logic [WIDTH-1:0] bias(input logic [WIDTH-1:0] v,
                                            input logic             sgn);
    logic [WIDTH-1:0] r;
    r = v;
    r[WIDTH-1] = v[WIDTH-1] ^ sgn;
    return r;
  endfunction

  // Pick the slice addressed by the index from both captured operands.
  always_comb begin
    a_slice = a_q[idx_q*SLICE +: SLICE];
    b_slice = b_q[idx_q*SLICE +: SLICE];
  end

  slice_compare #(
    .SLICE (SLICE)
  ) u_slice_compare (
    .x  (a_slice),
    .y  (b_slice),
    .lt (slice_lt),
    .eq (slice_eq)
  );

  // Next-state logic: capture in IDLE, walk slices in COMPARE, pulse in DONE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = bias(a, is_signed);
          b_d     = bias(b, is_signed);
          op_d    = op;
          idx_d   = IDX_MAX;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (!slice_eq) begin
          // First differing slice decides the whole compare.
          lt_d    = slice_lt;
          eq_d    = 1'b0;
          gt_d    = !slice_lt;
          res_d   = op_true(op_q, slice_lt, 1'b0, !slice_lt);
          state_d = DONE;
        end else if (idx_q == '0) begin
          // Every slice matched.
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          res_d   = op_true(op_q, 1'b0, 1'b1, 1'b0);
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      DONE: begin
        // start is not sampled here; a request must wait for IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= CMP_LT;
      idx_q   <= IDX_MAX;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the values from
      // before this edge, independent of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      res_q   <= res_d;
    end
  end

  // Handshake decodes straight from state; result is the truth bit zero-extended.
  always_comb begin
    busy   = (state_q == COMPARE);
    done   = (state_q == DONE);
    result = {{(WIDTH-1){1'b0}}, res_q};
    lt     = lt_q;
    eq     = eq_q;
    gt     = gt_q;
  end

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// Directed bench for seq_magnitude_compare: a 6-bit/2-bit-slice instance
// driven from a vector table, plus an 8-bit/1-bit-slice instance for the
// back-to-back sequence, with hand-written reset and busy-start sequences.
module tb_seq_magnitude_compare;

  localparam logic [1:0] OP_LT = 2'b00;
  localparam logic [1:0] OP_LE = 2'b01;
  localparam logic [1:0] OP_EQ = 2'b10;
  localparam logic [1:0] OP_GT = 2'b11;
  localparam int BUDGET = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Instance 0: WIDTH=6, SLICE=2
  logic       start0, sg0, busy0, done0, lt0, eq0, gt0;
  logic [5:0] a0, b0, res0;
  logic [1:0] op0;

  seq_magnitude_compare #(.WIDTH(6), .SLICE(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .op(op0),
    .is_signed(sg0), .busy(busy0), .done(done0), .result(res0),
    .lt(lt0), .eq(eq0), .gt(gt0)
  );

  // Instance 1: WIDTH=8, SLICE=1
  logic       start1, sg1, busy1, done1, lt1, eq1, gt1;
  logic [7:0] a1, b1, res1;
  logic [1:0] op1;

  seq_magnitude_compare #(.WIDTH(8), .SLICE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .op(op1),
    .is_signed(sg1), .busy(busy1), .done(done1), .result(res1),
    .lt(lt1), .eq(eq1), .gt(gt1)
  );

  int done1_pulses = 0;
  always @(negedge clk) if (done1 === 1'b1) done1_pulses++;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [1:0] op;
    logic       sg;
    logic       lt;
    logic       eq;
    logic       gt;
    logic [5:0] res;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one request on instance 0 and return the start-to-done latency
  // (0 on timeout) and busy as seen in the first cycle after acceptance.
  // Inputs are scrambled after capture to show they do not matter.
  task automatic run0(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op,
                      input logic sg, output int lat, output logic busy_first);
    @(negedge clk);
    a0 = a; b0 = b; op0 = op; sg0 = sg; start0 = 1'b1;
    lat = 0;
    busy_first = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start0 = 1'b0;
        busy_first = busy0;
        a0 = ~a; b0 = a; op0 = ~op; sg0 = ~sg;
      end
      if (done0 === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                      input logic sg, output int lat);
    @(negedge clk);
    a1 = a; b1 = b; op1 = op; sg1 = sg; start1 = 1'b1;
    lat = 0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start1 = 1'b0;
        a1 = ~a; b1 = ~b;
      end
      if (done1 === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    logic bf;
    int   pulses;
    int   first_done;

    vecs[0]  = '{a:6'h2A, b:6'h15, op:OP_LT, sg:1'b0, lt:1'b0, eq:1'b0, gt:1'b1, res:6'h00, lat:2};
    vecs[1]  = '{a:6'h1B, b:6'h1B, op:OP_LE, sg:1'b0, lt:1'b0, eq:1'b1, gt:1'b0, res:6'h01, lat:4};
    vecs[2]  = '{a:6'h3F, b:6'h01, op:OP_LT, sg:1'b1, lt:1'b1, eq:1'b0, gt:1'b0, res:6'h01, lat:2};
    vecs[3]  = '{a:6'h3F, b:6'h01, op:OP_LT, sg:1'b0, lt:1'b0, eq:1'b0, gt:1'b1, res:6'h00, lat:2};
    vecs[4]  = '{a:6'h24, b:6'h21, op:OP_GT, sg:1'b0, lt:1'b0, eq:1'b0, gt:1'b1, res:6'h01, lat:3};
    vecs[5]  = '{a:6'h22, b:6'h21, op:OP_GT, sg:1'b0, lt:1'b0, eq:1'b0, gt:1'b1, res:6'h01, lat:4};
    vecs[6]  = '{a:6'h20, b:6'h1F, op:OP_GT, sg:1'b1, lt:1'b1, eq:1'b0, gt:1'b0, res:6'h00, lat:2};
    vecs[7]  = '{a:6'h2A, b:6'h2A, op:OP_EQ, sg:1'b1, lt:1'b0, eq:1'b1, gt:1'b0, res:6'h01, lat:4};
    vecs[8]  = '{a:6'h05, b:6'h06, op:OP_LE, sg:1'b0, lt:1'b1, eq:1'b0, gt:1'b0, res:6'h01, lat:4};
    vecs[9]  = '{a:6'h10, b:6'h11, op:OP_EQ, sg:1'b0, lt:1'b1, eq:1'b0, gt:1'b0, res:6'h00, lat:4};
    vecs[10] = '{a:6'h01, b:6'h3E, op:OP_GT, sg:1'b1, lt:1'b0, eq:1'b0, gt:1'b1, res:6'h01, lat:2};
    vecs[11] = '{a:6'h00, b:6'h3F, op:OP_LT, sg:1'b0, lt:1'b1, eq:1'b0, gt:1'b0, res:6'h01, lat:2};

    rst_n = 1'b0;
    start0 = 1'b0; a0 = '0; b0 = '0; op0 = '0; sg0 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; op1 = '0; sg1 = 1'b0;

    // Reset state
    #12;
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_result", res0, 6'h00);
    check("rst_flags", {lt0, eq0, gt0}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors on the 6-bit instance
    foreach (vecs[i]) begin
      run0(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sg, lat, bf);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy", i), bf, 1'b1);
      check($sformatf("v%0d_flags", i), {lt0, eq0, gt0}, {vecs[i].lt, vecs[i].eq, vecs[i].gt});
      check($sformatf("v%0d_result", i), res0, vecs[i].res);
    end

    // Outputs hold in IDLE after the last request
    repeat (3) @(negedge clk);
    check("hold_busy_done", {busy0, done0}, 2'b00);
    check("hold_result", res0, 6'h01);
    check("hold_flags", {lt0, eq0, gt0}, 3'b100);

    // start while busy and while in DONE is ignored: one done pulse only
    @(negedge clk);
    a0 = 6'h24; b0 = 6'h21; op0 = OP_GT; sg0 = 1'b0; start0 = 1'b1;
    pulses = 0;
    first_done = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        pulses++;
        if (first_done == 0) first_done = k;
      end
      case (k)
        1: start0 = 1'b0;
        2: begin start0 = 1'b1; a0 = 6'h00; b0 = 6'h3F; op0 = OP_LT; end
        3: begin start0 = 1'b1; a0 = 6'h00; b0 = 6'h00; op0 = OP_EQ; end
        4: start0 = 1'b0;
        default: ;
      endcase
    end
    check("busy_start_pulses", pulses, 1);
    check("busy_start_latency", first_done, 3);
    check("busy_start_result", res0, 6'h01);
    check("busy_start_flags", {lt0, eq0, gt0}, 3'b001);

    // Reset in the middle of a compare
    @(negedge clk);
    a0 = 6'h10; b0 = 6'h10; op0 = OP_LE; sg0 = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("abort_busy_before", busy0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy0, 1'b0);
    check("abort_done", done0, 1'b0);
    check("abort_result", res0, 6'h00);
    check("abort_flags", {lt0, eq0, gt0}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0 === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run0(6'h10, 6'h10, OP_EQ, 1'b0, lat, bf);
    check("after_abort_latency", lat, 4);
    check("after_abort_flags", {lt0, eq0, gt0}, 3'b010);
    check("after_abort_result", res0, 6'h01);

    // 8-bit, 1-bit slices, back-to-back requests
    done1_pulses = 0;
    run1(8'h80, 8'h7F, OP_LT, 1'b1, lat);
    check("w8_signed_latency", lat, 2);
    check("w8_signed_flags", {lt1, eq1, gt1}, 3'b100);
    check("w8_signed_result", res1, 8'h01);
    run1(8'h00, 8'h00, OP_EQ, 1'b0, lat);
    check("w8_eq_latency", lat, 9);
    check("w8_eq_flags", {lt1, eq1, gt1}, 3'b010);
    check("w8_eq_result", res1, 8'h01);
    repeat (3) @(negedge clk);
    check("w8_done_pulses", done1_pulses, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
